// File: rtl/any1_vmseq_if.sv
// rtl/any1_vmseq_if.sv - memory request and load writeback port of the vector memory sequencer
interface any1_vmseq_if;
    logic       mem_req;
    logic       mem_we;
    logic [5:0] mem_elem;
    logic       mem_ack;
    logic       ld_wr;
    logic [5:0] ld_elem;

    modport master (
        output mem_req, mem_we, mem_elem, ld_wr, ld_elem,
        input  mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_elem, ld_wr, ld_elem,
        output mem_ack
    );
endinterface

// File: rtl/any1_vmseq.sv
// rtl/any1_vmseq.sv - vector memory element sequencer: walks active elements, one request per element
module any1_vmseq (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                is_store,
    input  logic [6:0]          vl,
    input  logic [63:0]         mask,
    input  logic                mask_en,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic [5:0]          step,
    any1_vmseq_if.master        mem
);
    localparam int NELEM = 64;

    typedef enum logic [1:0] {S_IDLE, S_AGEN, S_REQ, S_DONE} state_t;

    state_t      state, state_d;
    logic [6:0]  vl_c;
    logic [63:0] mask_c;
    logic        mask_en_c;
    logic        is_store_c;
    logic [5:0]  step_r, step_d;
    logic        ld_wr_r, ld_wr_d;
    logic [5:0]  ld_elem_r, ld_elem_d;
    logic        capture;

    logic [6:0]  vl_in;
    logic [6:0]  act_vl;
    logic [63:0] act_mask;
    logic        act_men;
    logic [6:0]  base;
    logic [63:0] act;
    logic [63:0] cand;
    logic        found;
    logic [5:0]  nxt;

    assign vl_in = (vl > 7'(NELEM)) ? 7'(NELEM) : vl;

    // In IDLE the search runs on the live operands so the first step is ready at the capturing edge
    always_comb begin
        if (state == S_IDLE) begin
            act_vl   = vl_in;
            act_mask = mask;
            act_men  = mask_en;
            base     = 7'd0;
        end else begin
            act_vl   = vl_c;
            act_mask = mask_c;
            act_men  = mask_en_c;
            base     = {1'b0, step_r} + 7'd1;
        end
        act = '0;
        for (int i = 0; i < NELEM; i++) begin
            act[i] = (7'(i) < act_vl) && (act_mask[i] || !act_men);
        end
        // base of 64 shifts every bit out, so the last element never wraps to 0
        cand  = act & ({64{1'b1}} << base);
        found = |cand;
        nxt   = '0;
        for (int i = NELEM - 1; i >= 0; i--) begin
            if (cand[i]) nxt = 6'(i);
        end
    end

    always_comb begin
        state_d   = state;
        step_d    = step_r;
        ld_wr_d   = 1'b0;
        ld_elem_d = ld_elem_r;
        capture   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    capture = 1'b1;
                    if (found) begin
                        step_d  = nxt;
                        state_d = S_AGEN;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_AGEN: state_d = S_REQ;
            S_REQ: begin
                if (mem.mem_ack) begin
                    ld_wr_d = !is_store_c;
                    if (!is_store_c) ld_elem_d = step_r;
                    if (found) begin
                        step_d  = nxt;
                        state_d = S_AGEN;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d   = S_IDLE;
            step_d    = step_r;
            ld_wr_d   = 1'b0;
            ld_elem_d = ld_elem_r;
            capture   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            step_r     <= '0;
            ld_wr_r    <= 1'b0;
            ld_elem_r  <= '0;
            vl_c       <= '0;
            mask_c     <= '0;
            mask_en_c  <= 1'b0;
            is_store_c <= 1'b0;
        end else begin
            state     <= state_d;
            step_r    <= step_d;
            ld_wr_r   <= ld_wr_d;
            ld_elem_r <= ld_elem_d;
            if (capture) begin
                vl_c       <= vl_in;
                mask_c     <= mask;
                mask_en_c  <= mask_en;
                is_store_c <= is_store;
            end
        end
    end

    assign busy         = (state == S_AGEN) || (state == S_REQ);
    assign done         = (state == S_DONE);
    assign step         = step_r;
    assign mem.mem_req  = (state == S_REQ);
    assign mem.mem_we   = (state == S_REQ) && is_store_c;
    assign mem.mem_elem = step_r;
    assign mem.ld_wr    = ld_wr_r;
    assign mem.ld_elem  = ld_elem_r;
endmodule

// File: tb/tb_any1_vmseq.sv
// tb/tb_any1_vmseq.sv - scoreboard bench for the vector memory element sequencer
module tb_any1_vmseq;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [6:0]  vl = '0;
    logic [63:0] mask = '0;
    logic        mask_en = 1'b0;
    logic        abort = 1'b0;
    logic        busy, done;
    logic [5:0]  step;

    any1_vmseq_if mem ();

    any1_vmseq dut (
        .clk(clk), .rst(rst), .start(start), .is_store(is_store), .vl(vl),
        .mask(mask), .mask_en(mask_en), .abort(abort), .busy(busy),
        .done(done), .step(step), .mem(mem)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int start_cyc = 0;

    logic [6:0] exp_req[$];
    logic [5:0] exp_ld[$];
    int         exp_done[$];

    int         ack_delay = 0;
    bit         ack_always = 0;
    bit         abort_arm = 0;
    bit         abort_seen = 0;
    logic [5:0] abort_elem = '0;
    int         wcnt = 0;

    logic       pv_req = 1'b0;
    logic       pv_ack = 1'b0;
    logic       pv_we = 1'b0;
    logic [5:0] pv_elem = '0;
    logic [6:0] e_req;
    logic [5:0] e_ld;
    int         e_done;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // memory model
    initial begin
        mem.mem_ack = 1'b0;
        forever begin
            @(negedge clk);
            abort = 1'b0;
            mem.mem_ack = 1'b0;
            if (ack_always) begin
                mem.mem_ack = 1'b1;
            end else if (mem.mem_req) begin
                if (wcnt >= ack_delay) mem.mem_ack = 1'b1;
                else wcnt++;
            end else begin
                wcnt = 0;
            end
            if (abort_arm && mem.mem_req && mem.mem_ack && mem.mem_elem == abort_elem) begin
                abort = 1'b1;
                abort_arm = 0;
                abort_seen = 1;
            end
        end
    end

    // monitor
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                if (mem.mem_req && pv_req && !pv_ack) begin
                    check("req_hold_elem", mem.mem_elem, pv_elem);
                    check("req_hold_we", mem.mem_we, pv_we);
                end
                if (mem.mem_req && mem.mem_ack && !abort) begin
                    if (exp_req.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL unexpected_req: elem %0d, none expected", mem.mem_elem);
                    end else begin
                        e_req = exp_req.pop_front();
                        check("req_elem", mem.mem_elem, e_req[5:0]);
                        check("req_we", mem.mem_we, e_req[6]);
                        check("step_eq_elem", step, mem.mem_elem);
                    end
                end
                if (mem.ld_wr) begin
                    if (exp_ld.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL unexpected_ld_wr: elem %0d, none expected", mem.ld_elem);
                    end else begin
                        e_ld = exp_ld.pop_front();
                        check("ld_elem", mem.ld_elem, e_ld);
                    end
                end
                if (done) begin
                    if (exp_done.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL unexpected_done: at cycle %0d, none expected", cyc - start_cyc);
                    end else begin
                        e_done = exp_done.pop_front();
                        check("done_cycle", cyc - start_cyc, e_done);
                        check("busy_in_done", busy, 0);
                    end
                end
            end
            pv_req  = mem.mem_req;
            pv_ack  = mem.mem_ack;
            pv_elem = mem.mem_elem;
            pv_we   = mem.mem_we;
        end
    end

    task automatic clear_inputs();
        start = 1'b0; is_store = 1'b0; vl = '0; mask = '0; mask_en = 1'b0;
    endtask

    task automatic issue(input logic st, input logic [6:0] v, input logic [63:0] m, input logic me);
        @(negedge clk);
        start = 1'b1; is_store = st; vl = v; mask = m; mask_en = me;
        start_cyc = cyc;
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic wait_done(input int budget, input bit glitch);
        int k;
        k = 0;
        while (exp_done.size() != 0 && k < budget) begin
            @(negedge clk);
            if (glitch && (k == 3 || k == 9)) begin
                start = 1'b1; is_store = 1'b1; vl = 7'd1; mask = '1; mask_en = 1'b0;
            end else begin
                clear_inputs();
            end
            #2;
            k++;
        end
        clear_inputs();
        check("done_seen", exp_done.size(), 0);
        check("req_drained", exp_req.size(), 0);
        check("ld_drained", exp_ld.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mem_req", mem.mem_req, 0);
        check("rst_mem_we", mem.mem_we, 0);
        check("rst_ld_wr", mem.ld_wr, 0);
        check("rst_step", step, 0);
        check("rst_mem_elem", mem.mem_elem, 0);
        check("rst_ld_elem", mem.ld_elem, 0);
        @(negedge clk);
        rst = 1'b1;

        // vl=4 load, ack held high throughout
        ack_always = 1;
        for (int i = 0; i < 4; i++) begin
            exp_req.push_back({1'b0, 6'(i)});
            exp_ld.push_back(6'(i));
        end
        exp_done.push_back(9);
        issue(1'b0, 7'd4, 64'h0, 1'b0);
        wait_done(40, 0);
        ack_always = 0;

        // store of elements 0 and 63 only
        exp_req.push_back({1'b1, 6'd0});
        exp_req.push_back({1'b1, 6'd63});
        exp_done.push_back(5);
        issue(1'b1, 7'd64, 64'h8000_0000_0000_0001, 1'b1);
        wait_done(40, 0);
        check("step_hold_63", step, 63);
        repeat (2) @(negedge clk);
        #2;
        check("step_hold_63_idle", step, 63);

        // vl beyond 64 clamps
        exp_req.push_back({1'b0, 6'd2});
        exp_req.push_back({1'b0, 6'd63});
        exp_ld.push_back(6'd2);
        exp_ld.push_back(6'd63);
        exp_done.push_back(5);
        issue(1'b0, 7'd127, 64'h8000_0000_0000_0004, 1'b1);
        wait_done(40, 0);

        // empty operations
        exp_done.push_back(1);
        issue(1'b0, 7'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        wait_done(10, 0);
        exp_done.push_back(1);
        issue(1'b0, 7'd8, 64'h0000_0000_0000_FF00, 1'b1);
        wait_done(10, 0);

        // slow memory with stray start pulses while busy
        ack_delay = 5;
        for (int i = 0; i < 3; i++) begin
            exp_req.push_back({1'b0, 6'(i)});
            exp_ld.push_back(6'(i));
        end
        exp_done.push_back(22);
        issue(1'b0, 7'd3, 64'h0, 1'b0);
        wait_done(60, 1);

        // abort coincident with the ack of element 1
        ack_delay = 0;
        abort_elem = 6'd1;
        abort_seen = 0;
        abort_arm = 1;
        exp_req.push_back({1'b0, 6'd0});
        exp_ld.push_back(6'd0);
        issue(1'b0, 7'd3, 64'h0, 1'b0);
        k = 0;
        while (!abort_seen && k < 20) begin
            @(negedge clk); #2; k++;
        end
        check("abort_reached", abort_seen, 1);
        @(negedge clk);
        #2;
        check("abort_busy", busy, 0);
        check("abort_mem_req", mem.mem_req, 0);
        check("abort_ld_wr", mem.ld_wr, 0);
        check("abort_done", done, 0);
        check("abort_req_drained", exp_req.size(), 0);
        check("abort_ld_drained", exp_ld.size(), 0);
        repeat (4) @(negedge clk);
        abort_arm = 0;
        exp_req.push_back({1'b1, 6'd0});
        exp_req.push_back({1'b1, 6'd1});
        exp_done.push_back(5);
        issue(1'b1, 7'd2, 64'h0, 1'b0);
        wait_done(40, 0);

        // asynchronous reset while element 1 is waiting in REQ
        ack_delay = 5;
        exp_req.push_back({1'b0, 6'd0});
        exp_ld.push_back(6'd0);
        issue(1'b0, 7'd3, 64'h0, 1'b0);
        k = 0;
        while (!(mem.mem_req && mem.mem_elem == 6'd1) && k < 40) begin
            @(negedge clk); #2; k++;
        end
        check("reached_req1", mem.mem_req && mem.mem_elem == 6'd1, 1);
        #1;
        rst = 1'b0;
        #1;
        check("arst_mem_req", mem.mem_req, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_step", step, 0);
        check("arst_mem_elem", mem.mem_elem, 0);
        check("arst_mem_we", mem.mem_we, 0);
        check("arst_ld_wr", mem.ld_wr, 0);
        check("arst_ld_elem", mem.ld_elem, 0);
        check("arst_req_drained", exp_req.size(), 0);
        check("arst_ld_drained", exp_ld.size(), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        check("post_rst_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
